// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard/stall scheduler.
package hazard_ctrl_pkg;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned REG_W       = 5;
   localparam int unsigned WAIT_W      = 16;
   localparam int unsigned TIMEOUT_DEF = 16;

   localparam logic [REG_W-1:0] ZeroReg5 = 5'd0;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_e;

   // Hold/bubble controls for the pipeline registers, in output order.
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_exe_stall;
      logic exe_mem_stall;
      logic if_id_flush;
      logic id_exe_flush;
      logic mem_wb_flush;
   } ctrl_t;

   // True when a source operand that is actually read matches a nonzero destination.
   function automatic logic src_hit(input logic [REG_W-1:0] src,
                                    input logic             used,
                                    input logic [REG_W-1:0] dest);
      return used && (dest != ZeroReg5) && (src == dest);
   endfunction

endpackage

// File: rtl/hazard_ctrl_cnt.sv
// Saturating up-counter with synchronous clear, used for stall statistics.
module hazard_ctrl_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: load-use, taken branch,
// multi-cycle data memory with timeout, and a sticky error state.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [REG_W-1:0]   id_reg_addr_1_i,
   input  logic [REG_W-1:0]   id_reg_addr_2_i,
   input  logic               id_uses_rs1_i,
   input  logic               id_uses_rs2_i,
   input  logic               ex_MemRead_i,
   input  logic [REG_W-1:0]   ex_reg_dest_i,
   input  logic               ex_branch_taken_i,
   input  logic               mem_MemRead_i,
   input  logic               mem_MemWrite_i,
   input  logic               dmem_ack_i,
   output logic               pc_stall_o,
   output logic               if_id_stall_o,
   output logic               id_exe_stall_o,
   output logic               exe_mem_stall_o,
   output logic               if_id_flush_o,
   output logic               id_exe_flush_o,
   output logic               mem_wb_flush_o,
   output logic               err_o,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   stall_cycles_o
);

   state_e            state_q;
   state_e            state_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;

   logic  access;
   logic  freeze;
   logic  load_use;
   ctrl_t ctrl;

   assign access   = mem_MemRead_i | mem_MemWrite_i;
   assign load_use = ex_MemRead_i &
                     (src_hit(id_reg_addr_1_i, id_uses_rs1_i, ex_reg_dest_i) |
                      src_hit(id_reg_addr_2_i, id_uses_rs2_i, ex_reg_dest_i));

   always_comb begin
      freeze = 1'b0;
      unique case (state_q)
         ST_RUN:      freeze = access & ~dmem_ack_i;
         ST_MEM_WAIT: freeze = ~dmem_ack_i;
         ST_ERROR:    freeze = 1'b1;
         default:     freeze = 1'b1;
      endcase
   end

   // State and wait-counter register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state; an ack on the timeout cycle still wins over the error.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         ST_RUN: begin
            if (access && !dmem_ack_i) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ack_i) begin
               state_d = ST_RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_W'(TIMEOUT)) begin
               state_d = ST_ERROR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase
   end

   // Control outputs by priority: freeze, then branch, then load-use.
   always_comb begin
      ctrl = '0;
      if (!rst_i) begin
         ctrl = '0;
      end else if (freeze) begin
         ctrl.pc_stall      = 1'b1;
         ctrl.if_id_stall   = 1'b1;
         ctrl.id_exe_stall  = 1'b1;
         ctrl.exe_mem_stall = 1'b1;
         ctrl.mem_wb_flush  = 1'b1;
      end else if (ex_branch_taken_i) begin
         ctrl.if_id_flush  = 1'b1;
         ctrl.id_exe_flush = 1'b1;
      end else if (load_use) begin
         ctrl.pc_stall     = 1'b1;
         ctrl.if_id_stall  = 1'b1;
         ctrl.id_exe_flush = 1'b1;
      end
   end

   assign pc_stall_o      = ctrl.pc_stall;
   assign if_id_stall_o   = ctrl.if_id_stall;
   assign id_exe_stall_o  = ctrl.id_exe_stall;
   assign exe_mem_stall_o = ctrl.exe_mem_stall;
   assign if_id_flush_o   = ctrl.if_id_flush;
   assign id_exe_flush_o  = ctrl.id_exe_flush;
   assign mem_wb_flush_o  = ctrl.mem_wb_flush;
   assign err_o           = (state_q == ST_ERROR);
   assign state_o         = state_q;

   hazard_ctrl_cnt #(
      .W (CNT_W)
   ) u_perf_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (|ctrl),
      .cnt_o (stall_cycles_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the scheduling rules.
module tb_hazard_ctrl;

   localparam int unsigned TMO   = 4;
   localparam int unsigned CW    = 4;
   localparam int unsigned EXP_W = 7 + 1 + 2 + CW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic [4:0]    a1 = '0, a2 = '0, rd = '0;
   logic          u1 = 1'b0, u2 = 1'b0, exmr = 1'b0, br = 1'b0;
   logic          mr = 1'b0, mw = 1'b0, ack = 1'b0;
   logic          pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, memwb_fl, err;
   logic [1:0]    st;
   logic [CW-1:0] scnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [EXP_W-1:0] v;
      string            tag;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state: mode 0=run, 1=waiting on memory, 2=error.
   int m_mode, m_wait, m_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .id_reg_addr_1_i   (a1),
      .id_reg_addr_2_i   (a2),
      .id_uses_rs1_i     (u1),
      .id_uses_rs2_i     (u2),
      .ex_MemRead_i      (exmr),
      .ex_reg_dest_i     (rd),
      .ex_branch_taken_i (br),
      .mem_MemRead_i     (mr),
      .mem_MemWrite_i    (mw),
      .dmem_ack_i        (ack),
      .pc_stall_o        (pc_st),
      .if_id_stall_o     (ifid_st),
      .id_exe_stall_o    (idex_st),
      .exe_mem_stall_o   (exmem_st),
      .if_id_flush_o     (ifid_fl),
      .id_exe_flush_o    (idex_fl),
      .mem_wb_flush_o    (memwb_fl),
      .err_o             (err),
      .state_o           (st),
      .stall_cycles_o    (scnt)
   );

   function automatic logic [EXP_W-1:0] actual();
      return {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, memwb_fl, err, st, scnt};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (actual() !== e.v) begin
               failures++;
               $display("FAIL %s: got %b expected %b at %0t", e.tag, actual(), e.v, $time);
            end
         end
      end
   end

   // Drive one cycle of inputs, predict the response, advance the model.
   task automatic cyc(input string tag, input logic [4:0] i_a1, input logic i_u1,
                      input logic [4:0] i_a2, input logic i_u2, input logic i_exmr,
                      input logic [4:0] i_rd, input logic i_br, input logic i_mr,
                      input logic i_mw, input logic i_ack);
      bit   acc, frz, lu, any;
      logic [6:0] c;
      exp_t e;
      @(posedge clk);
      #1;
      a1 = i_a1; u1 = i_u1; a2 = i_a2; u2 = i_u2; exmr = i_exmr; rd = i_rd;
      br = i_br; mr = i_mr; mw = i_mw; ack = i_ack;
      acc = i_mr || i_mw;
      frz = (m_mode == 2) || (m_mode == 1 && !i_ack) || (m_mode == 0 && acc && !i_ack);
      lu  = i_exmr && (i_rd != 0) && ((i_u1 && i_a1 == i_rd) || (i_u2 && i_a2 == i_rd));
      if (frz)       c = 7'b1111_001;
      else if (i_br) c = 7'b0000_110;
      else if (lu)   c = 7'b1100_010;
      else           c = 7'b0000_000;
      e.v   = {c, (m_mode == 2), 2'(m_mode), CW'(m_cnt)};
      e.tag = tag;
      exp_q.push_back(e);
      any = (c != 0);
      if (any && m_cnt < (1 << CW) - 1) m_cnt++;
      case (m_mode)
         0: if (acc && !i_ack) begin m_mode = 1; m_wait = 1; end
         1: begin
            if (i_ack) begin m_mode = 0; m_wait = 0; end
            else if (m_wait == int'(TMO)) m_mode = 2;
            else m_wait++;
         end
         default: m_mode = 2;
      endcase
   endtask

   task automatic idle_inputs();
      a1 = '0; a2 = '0; rd = '0; u1 = 0; u2 = 0; exmr = 0; br = 0; mr = 0; mw = 0; ack = 0;
   endtask

   // Reset asserted a few ns after an edge, checked immediately, then released.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      rst_i = 1'b0;
      #1;
      check({tag, "_ctrl"}, 32'({pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, memwb_fl}), 32'd0);
      check({tag, "_state"}, 32'(st), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_cnt"}, 32'(scnt), 32'd0);
      idle_inputs();
      m_mode = 0; m_wait = 0; m_cnt = 0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
   endtask

   initial begin
      m_mode = 0; m_wait = 0; m_cnt = 0;
      idle_inputs();
      #12;
      check("reset_ctrl", 32'({pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, memwb_fl}), 32'd0);
      check("reset_state", 32'(st), 32'd0);
      check("reset_cnt", 32'(scnt), 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b1;

      // Load-use for one cycle, then the load leaves EXE.
      cyc("lu_hit",   5'd5, 1, 5'd7, 1, 1, 5'd5, 0, 0, 0, 0);
      cyc("lu_after", 5'd5, 1, 5'd7, 1, 0, 5'd9, 0, 1, 0, 1);
      cyc("lu_rs2",   5'd1, 1, 5'd6, 1, 1, 5'd6, 0, 0, 0, 0);
      cyc("lu_unused",5'd6, 0, 5'd2, 1, 1, 5'd6, 0, 0, 0, 0);
      cyc("lu_rd0",   5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);
      // Branch beats a simultaneous load-use.
      cyc("br_lu",    5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0);
      cyc("idle",     5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
      // Memory acked on first cycle: no stall.
      cyc("mem_fast", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
      // Memory wait of 3 frozen cycles, branch during freeze ignored.
      cyc("mw1",      5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
      cyc("mw2_br",   5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0);
      cyc("mw3",      5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 1, 0, 0);
      cyc("mw_ack",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
      cyc("mw_done",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
      // Ack on the timeout boundary still returns to run.
      cyc("bd1",      5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      for (int i = 0; i < int'(TMO) - 1; i++)
         cyc("bd_wait", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      cyc("bd_ack",   5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
      cyc("bd_done",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
      // Timeout: no ack ever; error holds and the perf counter saturates.
      for (int i = 0; i < int'(TMO) + 22; i++)
         cyc("timeout", 5'd0, 0, 5'd0, 0, 0, 5'd0, (i % 3) == 0, 1, 0, 0);
      cyc("err_ack",  5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
      do_reset("rst_err");
      cyc("post_rst", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
      // Asynchronous reset while waiting on memory.
      cyc("am1",      5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
      cyc("am2",      5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
      do_reset("rst_mid");
      cyc("post_rst2",5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

      // Randomized traffic in blocks, resetting between blocks.
      for (int blk = 0; blk < 6; blk++) begin
         for (int i = 0; i < 60; i++) begin
            cyc("rand",
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0),
                1'($urandom_range(0, 3) != 0));
         end
         do_reset("rst_rand");
      end

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall scheduler for the five-stage core. It sequences the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers by generating hold (stall) and bubble (flush) controls. It resolves four conditions: load-use data hazards, taken branches resolved in EXE, multi-cycle data-memory accesses (a request/acknowledge handshake with timeout), and a sticky error state. The block sits beside the pipeline registers; every register's enable and clear come from here.

## Interface
- TIMEOUT, 16, max cycles in MEM_WAIT before error; legal range 1..65535
- CNT_W, 32, width of stall performance counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_reg_addr_1_i / id_reg_addr_2_i  in  5  rs1/rs2 of instruction in ID
- id_uses_rs1_i / id_uses_rs2_i  in  1  instruction in ID reads rs1/rs2
- ex_MemRead_i  in  1  instruction in EXE is a load
- ex_reg_dest_i  in  5  rd of instruction in EXE
- ex_branch_taken_i  in  1  branch in EXE resolved taken
- mem_MemRead_i / mem_MemWrite_i  in  1  MEM stage holds a load/store
- dmem_ack_i  in  1  data memory completes access this cycle
- pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o  out  1  hold register
- if_id_flush_o, id_exe_flush_o, mem_wb_flush_o  out  1  load zero controls (bubble) at next edge
- err_o  out  1  sticky memory timeout
- state_o  out  2  current state (RUN=0, MEM_WAIT=1, ERROR=2)
- stall_cycles_o  out  CNT_W  saturating count of cycles with any stall/flush asserted

## Operation
- Outputs are Mealy: a combinational function of the state and the current inputs. State, wait counter and perf counter are registered.
- Definitions:
  - access = mem_MemRead_i | mem_MemWrite_i.
  - freeze = (state==RUN & access & ~dmem_ack_i) | (state==MEM_WAIT & ~dmem_ack_i) | state==ERROR.
  - load_use = ex_MemRead_i & ex_reg_dest_i!=0 & ((id_uses_rs1_i & id_reg_addr_1_i==ex_reg_dest_i) | (id_uses_rs2_i & id_reg_addr_2_i==ex_reg_dest_i)).
- Priority: freeze > branch > load_use.
  - freeze: pc, if_id, id_exe and exe_mem stalls=1; mem_wb_flush_o=1, so the MEM result is not written back twice. All other flushes are 0; branch and load_use are ignored.
  - branch (ex_branch_taken_i & ~freeze): if_id_flush_o=1, id_exe_flush_o=1, no stalls. A concurrent load_use is ignored, because the ID instruction is squashed.
  - load_use (no freeze, no branch): pc_stall_o=1, if_id_stall_o=1, id_exe_flush_o=1.
  - Otherwise all controls are 0.
- State transitions:
  - RUN→MEM_WAIT when access & ~dmem_ack_i. The wait counter loads 1.
  - MEM_WAIT: if dmem_ack_i, go to RUN and clear the counter. The freeze drops in this same ack cycle.
  - MEM_WAIT: else if counter==TIMEOUT, go to ERROR; else increment the counter.
  - ERROR is absorbing until reset. In ERROR, err_o=1 and freeze=1.
- Perf counter: increments each cycle any stall or flush output is 1. It saturates at all-ones.
- Reset (rst_i low, at any time including mid-MEM_WAIT):
  - state=RUN, wait counter=0, stall_cycles_o=0, err_o=0.
  - All stall/flush outputs are forced to 0 while rst_i is low.

## Timing
- Zero-latency controls: a hazard presented in cycle N asserts its controls in cycle N, and they take effect at the edge ending cycle N.
- Load-use costs exactly 1 bubble. In cycle N+1 the load has moved to MEM, so load_use deasserts naturally.
- Taken branch costs 2 squashed instructions (IF/ID and ID/EXE), both in one cycle.
- Memory access acked in its first MEM cycle: no stall, state stays RUN.
- Memory access acked k cycles after it first appears in MEM: freeze lasts k cycles.
- Ack arriving on the cycle the counter equals TIMEOUT: ack wins, go to RUN. ERROR is entered only if the ack is still absent at that point.
- Exact timeout behaviour: with no ack ever, the state is ERROR at cycle TIMEOUT+1 after the first MEM cycle.
- rst_i deassertion has no synchronizer requirement inside this block; the top level provides synchronous release.

## Structure
- The shared define package holds the state encodings (RUN/MEM_WAIT/ERROR as 2-bit constants), a ZeroReg5 address constant and the TIMEOUT default.
- One sub-module is natural: hazard_ctrl_cnt, a saturating up-counter with clear, instantiated for the perf counter. The wait counter stays inline.

## Test plan
- Load-use: EXE has lw x5 (ex_MemRead_i=1, ex_reg_dest_i=5); ID has add rs1=5 → pc_stall_o=if_id_stall_o=id_exe_flush_o=1 for exactly 1 cycle. Repeat with rd=0 → no stall.
- Branch vs load-use in the same cycle: ex_branch_taken_i=1 and load_use true → only if_id_flush_o and id_exe_flush_o=1, no stalls; stall_cycles_o +1.
- Memory wait: access held, dmem_ack_i low for 3 cycles then high → freeze for 3 cycles. state_o is 1 for cycles 2–4 and 0 after the ack edge. A branch asserted during the freeze produces no flush.
- Timeout: TIMEOUT=4, ack never arrives → state_o=2 and err_o=1 after 5 cycles; stalls held indefinitely. rst_i low then high → all outputs 0, state RUN.
- Ack on the boundary: ack arrives the cycle the counter==TIMEOUT → return to RUN, err_o stays 0.
- Async reset mid-MEM_WAIT: drop rst_i between clock edges → outputs 0 immediately, stall_cycles_o=0. Drive the perf counter with CNT_W=4 for 20 stall cycles → it holds at 15.
